// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
//   Bundles the request/grant signals of the shared core data bus arbiter.
//
//   Handshake: each source raises req[i] and holds it for as long as it wants
//   the bus. Ownership is signalled by grant[i] (registered, one-hot or zero).
//   The owner drops req[i] to give the bus back; there is no other release
//   signal. selectIn/busValid/holdCount describe the current owner.
//
//   Modports:
//     master : request side (drives req, observes grant/selectIn/...)
//     slave  : arbiter side (observes req, drives grant/selectIn/...)
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int NUM_REQ    = 9,
    parameter int SEL_WIDTH  = 4,
    parameter int HOLD_WIDTH = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    grant;
    logic [SEL_WIDTH-1:0]  selectIn;
    logic                  busValid;
    logic [HOLD_WIDTH-1:0] holdCount;

    modport master (
        output req,
        input  grant,
        input  selectIn,
        input  busValid,
        input  holdCount
    );

    modport slave (
        input  req,
        output grant,
        output selectIn,
        output busValid,
        output holdCount
    );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter/sequencer for the processor-core data bus. Source
//   index i maps directly to bus mux select code i; IDLE_SEL is driven when
//   nobody owns the bus. Each ownership is bounded by MAX_HOLD cycles when a
//   competitor is waiting, and an optional idle turnaround cycle separates
//   consecutive owners.
//
//   Ports:
//     clk        : system clock, rising edge
//     rst        : synchronous, active-high reset
//     bus        : bus_arbiter_if.slave (req in; grant/selectIn/busValid/
//                  holdCount out, all registered)
//     dbg_state  : current FSM state (0=IDLE, 1=GRANT, 2=GAP)
//     dbg_ptr    : current round-robin priority pointer
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_REQ    = 9,
    parameter int SEL_WIDTH  = 4,
    parameter int IDLE_SEL   = 9,
    parameter int MAX_HOLD   = 4,
    parameter int TURNAROUND = 1,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int HOLD_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_if.slave     bus,
    output logic [1:0]       dbg_state,
    output logic [IDX_W-1:0] dbg_ptr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [IDX_W-1:0]     owner_q,  owner_d;
    logic [IDX_W-1:0]     ptr_q,    ptr_d;
    logic [HOLD_W-1:0]    hold_q,   hold_d;
    logic [NUM_REQ-1:0]   grant_q,  grant_d;
    logic [SEL_WIDTH-1:0] sel_q,    sel_d;
    logic                 valid_q,  valid_d;

    logic [IDX_W-1:0]     rel_ptr;    // pointer after the current owner releases
    logic [IDX_W-1:0]     arb_ptr;    // pointer used by this edge's arbitration
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   other_req;
    logic                 owner_stays;

    // Pointer handling: when the owner releases, arbitration on the same
    // edge (TURNAROUND=0) must already use the advanced pointer, which also
    // puts a preempted owner at lowest priority.
    always_comb begin
        rel_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        arb_ptr = (state_q == ST_GRANT) ? rel_ptr : ptr_q;
    end

    // Rotating priority search starting at arb_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.req[(int'(arb_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(arb_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Owner keeps the bus while it still requests and either has time left
    // or nobody else is waiting.
    always_comb begin
        other_req          = bus.req;
        other_req[owner_q] = 1'b0;
        owner_stays        = bus.req[owner_q] &&
                             ((hold_q < HOLD_W'(MAX_HOLD)) || (other_req == '0));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_found) begin
                    state_d = ST_GRANT;
                    owner_d = win_idx;
                    hold_d  = HOLD_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            end

            ST_GRANT: begin
                if (owner_stays) begin
                    if (hold_q < HOLD_W'(MAX_HOLD)) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    ptr_d = rel_ptr;
                    if (TURNAROUND != 0) begin
                        state_d = ST_GAP;
                        hold_d  = '0;
                    end else if (win_found) begin
                        state_d = ST_GRANT;
                        owner_d = win_idx;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Registered bus outputs are a pure function of the next state.
    always_comb begin
        grant_d = '0;
        sel_d   = SEL_WIDTH'(IDLE_SEL);
        valid_d = 1'b0;
        if (state_d == ST_GRANT) begin
            grant_d[owner_d] = 1'b1;
            sel_d            = SEL_WIDTH'(owner_d);
            valid_d          = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            sel_q   <= SEL_WIDTH'(IDLE_SEL);
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.selectIn  = sel_q;
    assign bus.busValid  = valid_q;
    assign bus.holdCount = hold_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Drives two arbiters from the same request vector: u0 with a turnaround
//   cycle and u1 with back-to-back handover. A behavioural model tracks the
//   expected owner/hold/pointer of each and is compared every cycle; directed
//   sequences and a vector table cover the documented scenarios.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
    localparam int NUM_REQ  = 9;
    localparam int SEL_W    = 4;
    localparam int IDLE_SEL = 9;
    localparam int MAX_HOLD = 4;
    localparam int HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam int IDX_W    = $clog2(NUM_REQ);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_REQ-1:0] req = '0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_W), .HOLD_WIDTH(HOLD_W)) bif0 ();
    bus_arbiter_if #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_W), .HOLD_WIDTH(HOLD_W)) bif1 ();
    assign bif0.req = req;
    assign bif1.req = req;

    logic [1:0]       st0, st1;
    logic [IDX_W-1:0] ptr0, ptr1;

    bus_arbiter #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_W), .IDLE_SEL(IDLE_SEL),
                  .MAX_HOLD(MAX_HOLD), .TURNAROUND(1)) u0 (
        .clk(clk), .rst(rst), .bus(bif0), .dbg_state(st0), .dbg_ptr(ptr0));
    bus_arbiter #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_W), .IDLE_SEL(IDLE_SEL),
                  .MAX_HOLD(MAX_HOLD), .TURNAROUND(0)) u1 (
        .clk(clk), .rst(rst), .bus(bif1), .dbg_state(st1), .dbg_ptr(ptr1));

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 means nobody holds the bus (idle or turnaround).
    int m_own[2]  = '{-1, -1};
    int m_hold[2] = '{0, 0};
    int m_ptr[2]  = '{0, 0};

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // t=0 models the turnaround variant, t=1 the back-to-back variant.
    task automatic model_step(input int t);
        logic [NUM_REQ-1:0] others;
        int o;
        if (rst) begin
            m_own[t] = -1; m_hold[t] = 0; m_ptr[t] = 0;
            return;
        end
        o = m_own[t];
        if (o < 0) begin
            m_own[t]  = pick(req, m_ptr[t]);
            m_hold[t] = (m_own[t] >= 0) ? 1 : 0;
        end else begin
            others    = req;
            others[o] = 1'b0;
            if (req[o] && (m_hold[t] < MAX_HOLD || others == '0)) begin
                m_hold[t] = (m_hold[t] + 1 > MAX_HOLD) ? MAX_HOLD : m_hold[t] + 1;
            end else begin
                m_ptr[t] = (o + 1) % NUM_REQ;
                if (t == 0) begin
                    m_own[t] = -1; m_hold[t] = 0;
                end else begin
                    m_own[t]  = pick(req, m_ptr[t]);
                    m_hold[t] = (m_own[t] >= 0) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [NUM_REQ-1:0] eg;
        int es;
        for (int t = 0; t < 2; t++) begin
            eg = '0;
            es = IDLE_SEL;
            if (m_own[t] >= 0) begin
                eg[m_own[t]] = 1'b1;
                es = m_own[t];
            end
            if (t == 0) begin
                chk("m0_grant", 32'(bif0.grant),     32'(eg));
                chk("m0_sel",   32'(bif0.selectIn),  32'(es));
                chk("m0_valid", 32'(bif0.busValid),  32'(m_own[t] >= 0));
                chk("m0_hold",  32'(bif0.holdCount), 32'(m_hold[t]));
                chk("m0_ptr",   32'(ptr0),           32'(m_ptr[t]));
            end else begin
                chk("m1_grant", 32'(bif1.grant),     32'(eg));
                chk("m1_sel",   32'(bif1.selectIn),  32'(es));
                chk("m1_valid", 32'(bif1.busValid),  32'(m_own[t] >= 0));
                chk("m1_hold",  32'(bif1.holdCount), 32'(m_hold[t]));
                chk("m1_ptr",   32'(ptr1),           32'(m_ptr[t]));
            end
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change #1 after an edge; outputs are sampled #1 after the edge.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic               rst;
        logic [NUM_REQ-1:0] req;
        int                 sel0;
        int                 hold0;
        int                 sel1;
        int                 hold1;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Preemption rotation between sources 1 and 5 from pointer 0.
        int s0[11] = '{1, 1, 1, 1, 9, 5, 5, 5, 5, 9, 1};
        int h0[11] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
        int s1[11] = '{1, 1, 1, 1, 5, 5, 5, 5, 1, 1, 1};
        int h1[11] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3};
        tbl[0] = '{rst: 1'b1, req: '0, sel0: 9, hold0: 0, sel1: 9, hold1: 0};
        for (int i = 0; i < 11; i++)
            tbl[i+1] = '{rst: 1'b0, req: 9'h022, sel0: s0[i], hold0: h0[i],
                         sel1: s1[i], hold1: h1[i]};

        // ---- reset with all requests set ----
        rst = 1'b1; req = 9'h1FF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_grant", 32'(bif0.grant),     32'h0);
            chk("rst_sel",   32'(bif0.selectIn),  32'd9);
            chk("rst_valid", 32'(bif0.busValid),  32'd0);
            chk("rst_hold",  32'(bif0.holdCount), 32'd0);
        end
        rst = 1'b0; req = 9'h008;
        tick();
        chk("first_grant", 32'(bif0.grant),     32'h008);
        chk("first_sel",   32'(bif0.selectIn),  32'd3);
        chk("first_hold",  32'(bif0.holdCount), 32'd1);

        // ---- uncontested hold of source 2 ----
        do_reset();
        req = 9'h004;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("hold_sel",  32'(bif0.selectIn),  32'd2);
            chk("hold_cnt",  32'(bif0.holdCount), 32'((i > MAX_HOLD) ? MAX_HOLD : i));
        end
        req = '0;
        tick();
        chk("hold_gap_sel",   32'(bif0.selectIn), 32'd9);
        chk("hold_gap_state", 32'(st0),           32'd2);
        tick();
        chk("hold_idle_state", 32'(st0), 32'd0);

        // ---- table: rotation, both turnaround variants ----
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; req = tbl[i].req;
            tick();
            chk("tbl_sel0",  32'(bif0.selectIn),  32'(tbl[i].sel0));
            chk("tbl_hold0", 32'(bif0.holdCount), 32'(tbl[i].hold0));
            chk("tbl_sel1",  32'(bif1.selectIn),  32'(tbl[i].sel1));
            chk("tbl_hold1", 32'(bif1.holdCount), 32'(tbl[i].hold1));
            if (i > 0) chk("tbl_valid1", 32'(bif1.busValid), 32'd1);
        end
        rst = 1'b0;

        // ---- wrap-around from owner 8 ----
        do_reset();
        req = 9'h100;
        tick();
        chk("wrap_sel8", 32'(bif0.selectIn), 32'd8);
        req = 9'h081;
        tick();
        chk("wrap_gap", 32'(bif0.selectIn), 32'd9);
        chk("wrap_ptr", 32'(ptr0),          32'd0);
        tick();
        chk("wrap_sel0", 32'(bif0.selectIn), 32'd0);
        req = 9'h080;
        tick();
        chk("wrap_gap2", 32'(bif0.selectIn), 32'd9);
        tick();
        chk("wrap_sel7", 32'(bif0.selectIn), 32'd7);

        // ---- early release of source 4 ----
        do_reset();
        req = 9'h010;
        tick();
        tick();
        chk("early_hold", 32'(bif0.holdCount), 32'd2);
        req = '0;
        tick();
        chk("early_gap", 32'(bif0.selectIn), 32'd9);
        tick();
        chk("early_idle", 32'(st0),  32'd0);
        chk("early_ptr",  32'(ptr0), 32'd5);

        // ---- reset mid-grant of source 6 ----
        do_reset();
        req = 9'h040;
        tick();
        tick();
        chk("mid_sel6", 32'(bif0.selectIn), 32'd6);
        rst = 1'b1;
        tick();
        chk("mid_rst_grant", 32'(bif0.grant),    32'h0);
        chk("mid_rst_sel",   32'(bif0.selectIn), 32'd9);
        chk("mid_rst_ptr",   32'(ptr0),          32'd0);
        rst = 1'b0; req = 9'h044;
        tick();
        chk("mid_after_sel", 32'(bif0.selectIn), 32'd2);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) req[$urandom_range(0, NUM_REQ-1)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) req = '0;
            rst = ($urandom_range(0, 79) == 0);
            tick();
            chk("inv_valid0", 32'(bif0.busValid), 32'(bif0.grant != '0));
            chk("inv_onehot0", 32'($countones(bif0.grant) <= 1), 32'd1);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
